// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Imported by the fetch queue and the ifetch top.
package ifetch_pkg;

   typedef enum logic [1:0] {
      FS_REQ,
      FS_GAP,
      FS_HOLD
   } fetch_state_t;

   // Fill value for empty queue slots; never driven toward decode.
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   // Redirect targets are forced onto a word boundary.
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Bundle of icache, execute-redirect and decode signals seen by ifetch.
// master = fetch stage, slave = its environment.
interface ifetch_if;

   logic        pc_valid;
   logic [31:0] pc_addr;
   logic        instr_valid;
   logic [31:0] instr_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready;

   modport master (
      output pc_valid, pc_addr, if_valid, if_instr, if_pc,
      input  instr_valid, instr_data, redirect_valid, redirect_pc, id_ready
   );

   modport slave (
      input  pc_valid, pc_addr, if_valid, if_instr, if_pc,
      output instr_valid, instr_data, redirect_valid, redirect_pc, id_ready
   );

endinterface

// File: rtl/ifetch_fetch_queue.sv
// Small synchronous FIFO of {pc, instr} with flush and registered head.
// Head registers are updated on the same edge as the push/pop.
module fetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  fetch_entry_t             i_data,
   output logic                     o_valid,
   output fetch_entry_t             o_head,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   r_mem [DEPTH];
   logic [AW-1:0]  r_rd;
   logic [AW-1:0]  r_wr;
   logic [CW-1:0]  r_count;
   logic           r_valid;
   fetch_entry_t   r_head;

   logic           w_pop;
   logic [CW-1:0]  w_after_pop;
   logic [CW-1:0]  w_cnt_nxt;
   logic [AW-1:0]  w_rd_nxt;
   logic [AW-1:0]  w_wr_nxt;
   fetch_entry_t   w_head_nxt;

   assign w_pop   = i_pop && r_valid;
   assign o_valid = r_valid;
   assign o_head  = r_head;
   assign o_count = r_count;

   // Pointer and occupancy update; flush empties everything.
   always_comb begin
      w_after_pop = r_count - CW'(w_pop);
      w_cnt_nxt   = w_after_pop + CW'(i_push);
      w_rd_nxt    = r_rd + AW'(w_pop);
      w_wr_nxt    = r_wr + AW'(i_push);
      if (i_flush) begin
         w_cnt_nxt = '0;
         w_rd_nxt  = '0;
         w_wr_nxt  = '0;
      end
   end

   // Next head: bypass the pushed entry when it lands in an empty queue.
   always_comb begin
      w_head_nxt = r_head;
      if (!i_flush) begin
         if (w_after_pop != '0) begin
            w_head_nxt = r_mem[w_rd_nxt];
         end else if (i_push) begin
            w_head_nxt = i_data;
         end
      end
   end

   // Storage, pointers and registered head.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '{pc: 32'h0, instr: INSTR_NOP};
         end
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_head  <= '0;
      end else begin
         if (i_push && !i_flush) begin
            r_mem[r_wr] <= i_data;
         end
         r_rd    <= w_rd_nxt;
         r_wr    <= w_wr_nxt;
         r_count <= w_cnt_nxt;
         r_valid <= (w_cnt_nxt != '0);
         r_head  <= w_head_nxt;
      end
   end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, one-at-a-time icache requests, redirect handling.
// A response already in flight at redirect time is marked stale and dropped.
module ifetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic     clk,
   input  logic     rst,
   ifetch_if.master bus
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_t  r_state;
   fetch_state_t  w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nxt;
   logic [31:0]   r_addr;
   logic [31:0]   w_addr_nxt;
   logic          r_stale;
   logic          w_stale_nxt;
   logic          w_push;
   logic          w_pop;
   logic          w_credit;
   logic          w_q_valid;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_occ;
   logic [31:0]   w_target;
   fetch_entry_t  w_push_data;
   fetch_entry_t  w_head;

   assign w_target    = bus.redirect_pc & PC_ALIGN_MASK;
   assign w_pop       = bus.id_ready && w_q_valid;
   assign w_occ       = w_count - CW'(w_pop);
   assign w_credit    = w_occ < CW'(QDEPTH);
   assign w_push_data = '{pc: r_addr, instr: bus.instr_data};

   assign bus.pc_valid = (r_state == FS_REQ);
   assign bus.pc_addr  = r_addr;
   assign bus.if_valid = w_q_valid;
   assign bus.if_instr = w_head.instr;
   assign bus.if_pc    = w_head.pc;

   fetch_queue #(
      .DEPTH (QDEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (bus.id_ready),
      .i_flush (bus.redirect_valid),
      .i_data  (w_push_data),
      .o_valid (w_q_valid),
      .o_head  (w_head),
      .o_count (w_count)
   );

   // Fetch FSM: request, mandatory gap, and hold while the queue is full.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_addr_nxt  = r_addr;
      w_stale_nxt = r_stale;
      w_push      = 1'b0;
      unique case (r_state)
         FS_REQ: begin
            if (bus.instr_valid) begin
               w_state_nxt = FS_GAP;
               w_stale_nxt = 1'b0;
               if (bus.redirect_valid) begin
                  w_pc_nxt = w_target;
               end else if (!r_stale) begin
                  w_push   = 1'b1;
                  w_pc_nxt = r_addr + 32'd4;
               end
            end else if (bus.redirect_valid) begin
               w_stale_nxt = 1'b1;
               w_pc_nxt    = w_target;
            end
         end
         FS_GAP, FS_HOLD: begin
            if (bus.redirect_valid) begin
               w_state_nxt = FS_GAP;
               w_pc_nxt    = w_target;
            end else if (w_credit) begin
               w_state_nxt = FS_REQ;
               w_addr_nxt  = r_pc;
            end else begin
               w_state_nxt = FS_HOLD;
            end
         end
         default: w_state_nxt = FS_GAP;
      endcase
   end

   // State, PC, request address and stale flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FS_GAP;
         r_pc    <= RESET_PC;
         r_addr  <= RESET_PC;
         r_stale <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_addr  <= w_addr_nxt;
         r_stale <= w_stale_nxt;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: icache/decode/redirect stimulus, reference queue model.
// Directed scenarios first, then a long randomized run.
module tb_ifetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          QD     = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ifetch_if bus ();

   ifetch #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // reference model state
   ent_t        mq[$];
   logic        m_out;
   logic        m_stale;
   logic [31:0] m_pc;
   logic [31:0] m_addr;

   // observation logs
   logic [31:0] req_log[$];
   int          req_cyc[$];
   ent_t        pop_log[$];
   logic        prev_pcv;

   // icache / stimulus knobs
   int          lat_cnt;
   int          cur_lat;
   int          k_lat;
   int          k_rdy;
   bit          k_rr;
   bit          f_redir;
   bit          f_resp;
   logic [31:0] f_tgt;

   // values driven in the current cycle
   logic        d_ivalid;
   logic        d_redir;
   logic        d_rdy;
   logic [31:0] d_idata;
   logic [31:0] d_tgt;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   function automatic int pick_lat();
      return (k_lat != 0) ? k_lat : int'($urandom_range(1, 3));
   endfunction

   // drive inputs for this cycle, reacting to what the DUT shows now
   task automatic drive();
      d_ivalid = 1'b0;
      d_idata  = 32'h0;
      d_redir  = 1'b0;
      d_tgt    = 32'h0;
      if (bus.pc_valid) begin
         lat_cnt++;
         if (lat_cnt >= cur_lat || f_resp) begin
            d_ivalid = 1'b1;
            d_idata  = imem(bus.pc_addr);
            lat_cnt  = 0;
            cur_lat  = pick_lat();
         end
      end
      f_resp = 1'b0;
      if (f_redir) begin
         d_redir = 1'b1;
         d_tgt   = f_tgt;
         f_redir = 1'b0;
      end else if (k_rr && $urandom_range(0, 15) == 0) begin
         d_redir = 1'b1;
         if ($urandom_range(0, 3) == 0)
            d_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else
            d_tgt = $urandom;
      end
      case (k_rdy)
         0:       d_rdy = 1'b0;
         1:       d_rdy = 1'b1;
         default: d_rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (bus.if_valid && d_rdy)
         pop_log.push_back('{pc: bus.if_pc, instr: bus.if_instr});
      bus.instr_valid    = d_ivalid;
      bus.instr_data     = d_idata;
      bus.redirect_valid = d_redir;
      bus.redirect_pc    = d_tgt;
      bus.id_ready       = d_rdy;
   endtask

   // apply the fetch rules to the model for the edge just taken
   task automatic model_update();
      bit          pop;
      bit          room;
      bit          push;
      ent_t        pe;
      logic [31:0] tgt;
      tgt  = d_tgt & 32'hFFFF_FFFC;
      pop  = (mq.size() != 0) && d_rdy;
      room = (mq.size() - int'(pop)) < QD;
      push = 1'b0;
      pe   = '0;
      if (m_out) begin
         if (d_ivalid) begin
            m_out = 1'b0;
            if (!d_redir && !m_stale) begin
               push = 1'b1;
               pe   = '{pc: m_addr, instr: d_idata};
               m_pc = m_addr + 32'd4;
            end
            m_stale = 1'b0;
         end else if (d_redir) begin
            m_stale = 1'b1;
         end
         if (d_redir) m_pc = tgt;
      end else if (d_redir) begin
         m_pc = tgt;
      end else if (room) begin
         m_out  = 1'b1;
         m_addr = m_pc;
      end
      if (d_redir) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(pe);
      end
   endtask

   // compare DUT outputs with the model
   task automatic check();
      chk("pc_valid", 32'(bus.pc_valid), 32'(m_out));
      if (m_out) chk("pc_addr", bus.pc_addr, m_addr);
      chk("pc_addr_lsb", 32'(bus.pc_addr[1:0]), 32'h0);
      chk("if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("if_pc", bus.if_pc, mq[0].pc);
         chk("if_instr", bus.if_instr, mq[0].instr);
      end
      if (bus.pc_valid && !prev_pcv) begin
         req_log.push_back(bus.pc_addr);
         req_cyc.push_back(cyc);
      end
      prev_pcv = bus.pc_valid;
   endtask

   task automatic cycle();
      drive();
      @(posedge clk);
      cyc++;
      model_update();
      @(negedge clk);
      check();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst                = 1'b1;
      bus.instr_valid    = 1'b0;
      bus.instr_data     = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      mq.delete();
      req_log.delete();
      req_cyc.delete();
      pop_log.delete();
      m_out    = 1'b0;
      m_stale  = 1'b0;
      m_pc     = RST_PC;
      m_addr   = RST_PC;
      prev_pcv = 1'b0;
      lat_cnt  = 0;
      f_redir  = 1'b0;
      f_resp   = 1'b0;
      cur_lat  = pick_lat();
   endtask

   task automatic wait_pcv(input string nm);
      int i = 0;
      while (i < 40 && !bus.pc_valid) begin
         cycle();
         i++;
      end
      chk(nm, 32'(bus.pc_valid), 32'h1);
   endtask

   task automatic wait_reqs(input int n);
      int i = 0;
      while (i < 60 && req_log.size() < n) begin
         cycle();
         i++;
      end
   endtask

   initial begin
      int n;
      int np;
      int i;
      k_lat = 1;
      k_rdy = 1;
      k_rr  = 1'b0;
      bus.instr_valid    = 1'b0;
      bus.instr_data     = 32'h0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.id_ready       = 1'b0;

      // reset values
      @(negedge clk);
      @(negedge clk);
      chk("rst_pc_valid", 32'(bus.pc_valid), 32'h0);
      chk("rst_pc_addr", bus.pc_addr, RST_PC);
      chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
      chk("rst_if_instr", bus.if_instr, 32'h0);
      chk("rst_if_pc", bus.if_pc, 32'h0);

      // sequential fetch, 1-cycle icache, decode always ready
      k_lat = 1; k_rdy = 1; k_rr = 1'b0;
      do_reset();
      repeat (14) cycle();
      wait_reqs(3);
      if (req_log.size() >= 3) begin
         chk("seq_req0", req_log[0], 32'h0);
         chk("seq_req1", req_log[1], 32'h4);
         chk("seq_req2", req_log[2], 32'h8);
         chk("seq_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd2);
      end else chk("seq_req_timeout", 32'(req_log.size()), 32'd3);
      if (pop_log.size() >= 3) begin
         chk("seq_pop0_pc", pop_log[0].pc, 32'h0);
         chk("seq_pop0_in", pop_log[0].instr, imem(32'h0));
         chk("seq_pop1_pc", pop_log[1].pc, 32'h4);
         chk("seq_pop2_pc", pop_log[2].pc, 32'h8);
         chk("seq_pop2_in", pop_log[2].instr, imem(32'h8));
      end else chk("seq_pop_timeout", 32'(pop_log.size()), 32'd3);

      // decode stalled: two fetches then hold
      k_lat = 2; k_rdy = 0;
      do_reset();
      repeat (20) cycle();
      chk("hold_nreq", 32'(req_log.size()), 32'd2);
      if (req_log.size() >= 2) begin
         chk("hold_req0", req_log[0], 32'h0);
         chk("hold_req1", req_log[1], 32'h4);
      end
      chk("hold_pcv", 32'(bus.pc_valid), 32'h0);
      k_rdy = 1;
      cycle();
      chk("hold_release_pcv", 32'(bus.pc_valid), 32'h1);
      chk("hold_release_addr", bus.pc_addr, 32'h8);

      // redirect while request to 0x4 is pending
      k_lat = 3; k_rdy = 1;
      do_reset();
      i = 0;
      while (i < 40 && !(bus.pc_valid && bus.pc_addr == 32'h4)) begin
         cycle();
         i++;
      end
      chk("rd_pending4", 32'(bus.pc_valid && bus.pc_addr == 32'h4), 32'h1);
      n = req_log.size();
      f_redir = 1'b1;
      f_tgt   = 32'h0000_2088;
      cycle();
      np = pop_log.size();
      wait_reqs(n + 1);
      if (req_log.size() > n) chk("rd_next_req", req_log[n], 32'h2088);
      else chk("rd_next_req_timeout", 32'(req_log.size()), 32'(n + 1));
      i = 0;
      while (i < 40 && pop_log.size() <= np) begin
         cycle();
         i++;
      end
      if (pop_log.size() > np) chk("rd_first_pop", pop_log[np].pc, 32'h2088);
      else chk("rd_pop_timeout", 32'(pop_log.size()), 32'(np + 1));

      // redirect coincident with a response, unaligned target
      k_lat = 3;
      do_reset();
      wait_pcv("co_wait");
      f_resp  = 1'b1;
      f_redir = 1'b1;
      f_tgt   = 32'h0000_0103;
      cycle();
      chk("co_pcv_n1", 32'(bus.pc_valid), 32'h0);
      chk("co_if_valid", 32'(bus.if_valid), 32'h0);
      cycle();
      chk("co_pcv_n2", 32'(bus.pc_valid), 32'h1);
      chk("co_addr_n2", bus.pc_addr, 32'h100);

      // redirect near the top of memory: PC wraps to 0
      k_lat = 3;
      do_reset();
      wait_pcv("wrap_wait");
      n = req_log.size();
      f_redir = 1'b1;
      f_tgt   = 32'hFFFF_FFFE;
      cycle();
      wait_reqs(n + 2);
      if (req_log.size() >= n + 2) begin
         chk("wrap_req0", req_log[n], 32'hFFFF_FFFC);
         chk("wrap_req1", req_log[n + 1], 32'h0);
      end else chk("wrap_timeout", 32'(req_log.size()), 32'(n + 2));

      // asynchronous reset with a request outstanding and queue non-empty
      k_lat = 3; k_rdy = 0;
      do_reset();
      wait_reqs(2);
      chk("ar_setup", 32'(bus.pc_valid && bus.if_valid), 32'h1);
      rst = 1'b1;
      #1;
      chk("ar_pcv", 32'(bus.pc_valid), 32'h0);
      chk("ar_if_valid", 32'(bus.if_valid), 32'h0);
      k_rdy = 1;
      do_reset();
      wait_reqs(1);
      if (req_log.size() >= 1) chk("ar_first_req", req_log[0], RST_PC);
      else chk("ar_first_req_timeout", 32'(req_log.size()), 32'd1);

      // randomized run
      k_lat = 0; k_rdy = 2; k_rr = 1'b1;
      do_reset();
      repeat (3000) cycle();
      chk("rand_progress", 32'(pop_log.size() > 100), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
